// File: rtl/gray_cnt_pkg.sv
// ============================================================================
// Module      : gray_cnt_pkg
// Description : Shared definitions for the parametrised Gray-code counter.
//               Binary/Gray conversion helpers sized for the widest legal
//               counter. Narrower users cast the result down to their width.
//               The upper bits are zero because the input is zero-extended.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_cnt_pkg;

    localparam int GRAY_MAX_W = 16;

    // Overflow behaviour at the count boundaries.
    localparam int MODE_WRAP  = 0;
    localparam int MODE_SAT   = 1;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_step_chk.sv
// ============================================================================
// Module      : gray_step_chk
// Description : Sticky monitor for the counter's single-bit-step property.
//               A transition is flagged in either of these cases:
//                 - more than one Gray bit changes on a cycle that was not
//                   a clear or load;
//                 - any bit changes on a cycle that should have held.
//               A hold is expected when en was low, or when a saturated
//               boundary hold was in effect.
// Ports       : clk, rst_n     - clock, async active-low reset
//               gray_i         - registered Gray count under observation
//               resync_i       - clear or load is stepping the counter now
//               quiet_i        - counter is required to hold this cycle
//               step_err_o     - sticky error, cleared only by rst_n
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_step_chk #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_i,
    input  logic             resync_i,
    input  logic             quiet_i,
    output logic             step_err_o
);

    logic [WIDTH-1:0] prev_q;
    logic             resync_q;
    logic             quiet_q;
    logic             valid_q;
    logic             step_err_q;
    logic [WIDTH-1:0] diff_w;
    logic             multi_w;
    logic             err_d;

    // The qualifiers are registered alongside prev_q. This lets them describe
    // the same edge that produced the gray_i vs prev_q transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            resync_q   <= 1'b0;
            quiet_q    <= 1'b0;
            valid_q    <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            prev_q     <= gray_i;
            resync_q   <= resync_i;
            quiet_q    <= quiet_i;
            valid_q    <= 1'b1;
            step_err_q <= step_err_q | err_d;
        end
    end

    // Clearing the lowest set bit leaves a non-zero value only when the
    // popcount of the change mask is two or more.
    always_comb begin
        diff_w  = gray_i ^ prev_q;
        multi_w = (diff_w & (diff_w - 1'b1)) != '0;
        err_d   = 1'b0;
        if (valid_q && !resync_q) begin
            err_d = multi_w || (quiet_q && (diff_w != '0));
        end
    end

    assign step_err_o = step_err_q;

endmodule

`default_nettype wire

// File: rtl/gray_counter_param.sv
// ============================================================================
// Module      : gray_counter_param
// Description : Parametrised up/down Gray-code counter.
//               Supports enable, synchronous clear and parallel load.
//               At the boundaries it either wraps or saturates.
//               Gray and binary outputs are registered together, so
//               gray_count always equals bin2gray(bin_count).
//               Optional macro GRAY_CNT_STEP_CHK_EN adds a sticky step_err
//               output driven by the single-bit-step checker.
// Ports       : clk, rst_n          - clock, async active-low reset
//               en, up_dn          - step enable and direction (1 = up)
//               clear, load        - sync clear / parallel load (clear wins)
//               load_val           - binary value loaded by load
//               gray_count         - registered Gray count
//               bin_count          - registered binary count
//               at_max, at_min     - boundary flags decoded from bin_count
//               wrap               - one-cycle pulse after a wrapping step
//               step_err           - (GRAY_CNT_STEP_CHK_EN only) sticky error
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_counter_param
    import gray_cnt_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0,
    parameter int RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_count,
    output logic [WIDTH-1:0] bin_count,
    output logic             at_max,
    output logic             at_min,
`ifdef GRAY_CNT_STEP_CHK_EN
    output logic             wrap,
    output logic             step_err
`else
    output logic             wrap
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam bit               SAT_MODE = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (clear) begin
            bin_d = '0;
        end else if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (up_dn) begin
                if (bin_q != MAX_VAL) begin
                    bin_d = bin_q + 1'b1;
                end else if (!SAT_MODE) begin
                    bin_d  = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (bin_q != '0) begin
                    bin_d = bin_q - 1'b1;
                end else if (!SAT_MODE) begin
                    bin_d  = MAX_VAL;
                    wrap_d = 1'b1;
                end
            end
        end
        // Gray is derived from the next binary value so both register together.
        gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
    end

    assign gray_count = gray_q;
    assign bin_count  = bin_q;
    assign wrap       = wrap_q;
    assign at_max     = (bin_q == MAX_VAL);
    assign at_min     = (bin_q == '0);

`ifdef GRAY_CNT_STEP_CHK_EN
    logic sat_hold_w;
    logic quiet_w;

    assign sat_hold_w = SAT_MODE && en &&
                        ((up_dn && (bin_q == MAX_VAL)) || (!up_dn && (bin_q == '0)));
    assign quiet_w    = !clear && !load && (!en || sat_hold_w);

    gray_step_chk #(
        .WIDTH (WIDTH)
    ) u_step_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_i     (gray_q),
        .resync_i   (clear | load),
        .quiet_i    (quiet_w),
        .step_err_o (step_err)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_counter_param.sv
// ============================================================================
// Module      : tb_gray_counter_param
// Description : Directed self-checking bench for gray_counter_param.
//               Three instances share one stimulus:
//                 - wrapping counter, RST_VAL 0;
//                 - saturating counter;
//                 - wrapping counter, RST_VAL 5.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_counter_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       clear;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] g_w, b_w, g_s, b_s, g_r, b_r;
    logic       mx_w, mn_w, wr_w, mx_s, mn_s, wr_s, mx_r, mn_r, wr_r;
`ifdef GRAY_CNT_STEP_CHK_EN
    logic       se_w, se_s, se_r;
`endif

    int tests = 0;
    int fails = 0;

    gray_counter_param #(.WIDTH(4), .SATURATE(0), .RST_VAL(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .gray_count(g_w), .bin_count(b_w),
        .at_max(mx_w), .at_min(mn_w),
`ifdef GRAY_CNT_STEP_CHK_EN
        .wrap(wr_w), .step_err(se_w)
`else
        .wrap(wr_w)
`endif
    );

    gray_counter_param #(.WIDTH(4), .SATURATE(1), .RST_VAL(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .gray_count(g_s), .bin_count(b_s),
        .at_max(mx_s), .at_min(mn_s),
`ifdef GRAY_CNT_STEP_CHK_EN
        .wrap(wr_s), .step_err(se_s)
`else
        .wrap(wr_s)
`endif
    );

    gray_counter_param #(.WIDTH(4), .SATURATE(0), .RST_VAL(5)) dut_rv (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .gray_count(g_r), .bin_count(b_r),
        .at_max(mx_r), .at_min(mn_r),
`ifdef GRAY_CNT_STEP_CHK_EN
        .wrap(wr_r), .step_err(se_r)
`else
        .wrap(wr_r)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0; load_val = 4'd0;
        #2 rst_n = 1'b0;
        #1;
        tests++; if (b_w !== 4'd0 || g_w !== 4'b0000) begin fails++; $display("FAIL reset_w: bin=%b gray=%b expected 0000/0000", b_w, g_w); end
        tests++; if (wr_w !== 1'b0 || mn_w !== 1'b1 || mx_w !== 1'b0) begin fails++; $display("FAIL reset_flags: wrap=%b at_min=%b at_max=%b expected 0/1/0", wr_w, mn_w, mx_w); end
        tests++; if (b_r !== 4'd5 || g_r !== 4'b0111) begin fails++; $display("FAIL reset_rstval: bin=%b gray=%b expected 0101/0111", b_r, g_r); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_free_run_up();
        logic [3:0] gtab [16];
        logic [3:0] prev;
        gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        en = 1'b1; up_dn = 1'b1;
        prev = g_w;
        for (int i = 1; i <= 16; i++) begin
            tick();
            tests++;
            if (b_w !== 4'(i) || g_w !== gtab[i % 16] || wr_w !== (i == 16)) begin
                fails++;
                $display("FAIL free_run step %0d: bin=%b gray=%b wrap=%b expected %b/%b/%b",
                         i, b_w, g_w, wr_w, 4'(i), gtab[i % 16], (i == 16));
            end
            tests++;
            if ($countones(g_w ^ prev) != 1) begin
                fails++;
                $display("FAIL single_bit step %0d: prev=%b gray=%b expected one bit changed", i, prev, g_w);
            end
            prev = g_w;
        end
    endtask

    task automatic test_down_wrap();
        en = 1'b0; load = 1'b1; load_val = 4'd1;
        tick();
        tests++; if (b_w !== 4'd1 || g_w !== 4'b0001 || wr_w !== 1'b0) begin fails++; $display("FAIL load1: bin=%b gray=%b wrap=%b expected 0001/0001/0", b_w, g_w, wr_w); end
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        tick();
        tests++; if (b_w !== 4'd0 || g_w !== 4'b0000 || mn_w !== 1'b1 || wr_w !== 1'b0) begin fails++; $display("FAIL down_to_0: bin=%b gray=%b at_min=%b wrap=%b expected 0000/0000/1/0", b_w, g_w, mn_w, wr_w); end
        tick();
        tests++; if (b_w !== 4'd15 || g_w !== 4'b1000 || mx_w !== 1'b1 || wr_w !== 1'b1) begin fails++; $display("FAIL down_wrap: bin=%b gray=%b at_max=%b wrap=%b expected 1111/1000/1/1", b_w, g_w, mx_w, wr_w); end
        en = 1'b0;
        tick();
        tests++; if (b_w !== 4'd15 || wr_w !== 1'b0) begin fails++; $display("FAIL hold_after_wrap: bin=%b wrap=%b expected 1111/0", b_w, wr_w); end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_b [4];
        exp_b = '{4'd14, 4'd15, 4'd15, 4'd15};
        load = 1'b1; load_val = 4'd14; en = 1'b0;
        tick();
        tests++; if (b_s !== exp_b[0] || g_s !== 4'b1001) begin fails++; $display("FAIL sat_load: bin=%b gray=%b expected 1110/1001", b_s, g_s); end
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            tests++;
            if (b_s !== exp_b[i] || g_s !== 4'b1000 || mx_s !== 1'b1 || wr_s !== 1'b0) begin
                fails++;
                $display("FAIL sat_up %0d: bin=%b gray=%b at_max=%b wrap=%b expected %b/1000/1/0", i, b_s, g_s, mx_s, wr_s, exp_b[i]);
            end
        end
        // Down at 0 also holds.
        clear = 1'b1;
        tick();
        clear = 1'b0; up_dn = 1'b0;
        tick();
        tests++; if (b_s !== 4'd0 || wr_s !== 1'b0 || mn_s !== 1'b1) begin fails++; $display("FAIL sat_down: bin=%b wrap=%b at_min=%b expected 0000/0/1", b_s, wr_s, mn_s); end
        en = 1'b0;
    endtask

    task automatic test_priority();
        clear = 1'b1; load = 1'b1; load_val = 4'd9; en = 1'b1; up_dn = 1'b1;
        tick();
        tests++; if (b_w !== 4'd0 || g_w !== 4'b0000 || wr_w !== 1'b0) begin fails++; $display("FAIL prio_clear: bin=%b gray=%b wrap=%b expected 0000/0000/0", b_w, g_w, wr_w); end
        clear = 1'b0; en = 1'b0;
        tick();
        tests++; if (b_w !== 4'd9 || g_w !== 4'b1101) begin fails++; $display("FAIL prio_load: bin=%b gray=%b expected 1001/1101", b_w, g_w); end
        load = 1'b0;
    endtask

    task automatic test_back_to_back();
        load = 1'b1; load_val = 4'd3;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick();
        tests++; if (b_w !== 4'd4 || g_w !== 4'b0110) begin fails++; $display("FAIL rev_up: bin=%b gray=%b expected 0100/0110", b_w, g_w); end
        up_dn = 1'b0;
        tick();
        tests++; if (b_w !== 4'd3 || g_w !== 4'b0010) begin fails++; $display("FAIL rev_down: bin=%b gray=%b expected 0011/0010", b_w, g_w); end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 4'd5;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick();
        tests++; if (b_w !== 4'd6) begin fails++; $display("FAIL pre_reset: bin=%b expected 0110", b_w); end
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++; if (b_w !== 4'd0 || g_w !== 4'b0000 || wr_w !== 1'b0) begin fails++; $display("FAIL async_reset: bin=%b gray=%b wrap=%b expected 0000/0000/0", b_w, g_w, wr_w); end
        tests++; if (b_r !== 4'd5 || g_r !== 4'b0111) begin fails++; $display("FAIL async_rstval: bin=%b gray=%b expected 0101/0111", b_r, g_r); end
        #1 rst_n = 1'b1;
        en = 1'b1; up_dn = 1'b1;
        tick();
        tests++; if (b_r !== 4'd6 || g_r !== 4'b0101) begin fails++; $display("FAIL rstval_count: bin=%b gray=%b expected 0110/0101", b_r, g_r); end
        en = 1'b0;
    endtask

`ifdef GRAY_CNT_STEP_CHK_EN
    task automatic test_step_chk();
        logic [3:0] g;
        tick();
        tests++; if (se_w !== 1'b0 || se_s !== 1'b0 || se_r !== 1'b0) begin fails++; $display("FAIL step_err_clean: %b%b%b expected 000", se_w, se_s, se_r); end
        en = 1'b0;
        g = dut.gray_q;
        force dut.gray_q = g ^ 4'b0011;
        tick();
        tick();
        release dut.gray_q;
        tick();
        tick();
        tests++; if (se_w !== 1'b1) begin fails++; $display("FAIL step_err_set: %b expected 1", se_w); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (se_w !== 1'b0) begin fails++; $display("FAIL step_err_rst: %b expected 0", se_w); end
        #1 rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_free_run_up();
        test_down_wrap();
        test_saturate();
        test_priority();
        test_back_to_back();
        test_async_reset();
`ifdef GRAY_CNT_STEP_CHK_EN
        test_step_chk();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 ns");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
